fios_result_collector: RTL and testbench

- Receiving end of the cascaded DSP column in the 3A FIOS Montgomery datapath.
- Accepts the stream of 34-bit partial results (DSP P output, low 34 bits) one per cycle.
- Resolves carries into radix-2^17 words and buffers one full result of WORD_COUNT+1 words.
- Streams the words out on a valid/ready interface toward the result memory or final-subtraction stage.

---
 rtl/fios_result_collector.sv | 154 +++++++++++++++
 tb/tb_fios_result_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fios_result_collector.sv
// ============================================================================
// Module   : fios_result_collector
// Brief    : Collects 34-bit FIOS partial results, resolves radix-2^17 carries
//            and drains one WORD_COUNT+1 word result over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fios_result_collector #(
    parameter int WORD_WIDTH = 17,
    parameter int P_WIDTH    = 34,
    parameter int WORD_COUNT = 16
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  p_valid_i,
    input  logic [P_WIDTH-1:0]    p_i,
    input  logic                  p_last_i,
    output logic                  p_ready_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [WORD_WIDTH-1:0] res_word_o,
    output logic                  res_last_o,
    output logic                  overflow_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int c_PTR_W   = $clog2(WORD_COUNT + 1);
    localparam int c_ACC_W   = P_WIDTH + 1;
    localparam int c_CARRY_W = c_ACC_W - WORD_WIDTH;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST_IN  = c_PTR_W'(WORD_COUNT - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_OUT = c_PTR_W'(WORD_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_CARRY_W-1:0]    r_carry;
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic                    r_p_ready;
    logic                    r_res_valid;
    logic                    r_res_last;
    logic                    r_overflow;
    logic                    r_overrun;
    logic                    r_frame_err;
    logic [WORD_WIDTH-1:0]   r_buffer [0:WORD_COUNT];

    logic                    w_accept;
    logic                    w_last_in;
    logic                    w_res_hs;
    logic [c_ACC_W-1:0]      w_acc;

    assign w_accept  = p_valid_i & r_p_ready;
    assign w_last_in = (r_wr_ptr == c_LAST_IN);
    assign w_res_hs  = r_res_valid & res_ready_i;
    // Carry is at most 2^17+1, so the 35-bit sum can never wrap.
    assign w_acc     = {1'b0, p_i} + c_ACC_W'(r_carry);

    // Result storage is deliberately left out of reset.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (w_accept) begin
                r_buffer[r_wr_ptr] <= w_acc[WORD_WIDTH-1:0];
            end else if (r_state == ST_FLUSH) begin
                r_buffer[WORD_COUNT] <= r_carry[WORD_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_carry     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_p_ready   <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_overflow  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (p_valid_i && !r_p_ready) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_carry <= w_acc[c_ACC_W-1:WORD_WIDTH];
                // A misplaced or missing last marker is flagged; framing follows the count.
                if (p_last_i != w_last_in) begin
                    r_frame_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE, ST_COLLECT: begin
                    if (w_accept) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                        if (w_last_in) begin
                            r_state   <= ST_FLUSH;
                            r_p_ready <= 1'b0;
                        end else begin
                            r_state   <= ST_COLLECT;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_overflow  <= |r_carry[c_CARRY_W-1:WORD_WIDTH];
                    r_carry     <= '0;
                    r_rd_ptr    <= '0;
                    r_res_valid <= 1'b1;
                    r_res_last  <= 1'b0;
                    r_state     <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_res_hs) begin
                        if (r_res_last) begin
                            r_state     <= ST_IDLE;
                            r_res_valid <= 1'b0;
                            r_res_last  <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_wr_ptr    <= '0;
                            r_rd_ptr    <= '0;
                            r_p_ready   <= 1'b1;
                        end else begin
                            r_rd_ptr    <= r_rd_ptr + c_PTR_ONE;
                            r_res_last  <= ((r_rd_ptr + c_PTR_ONE) == c_LAST_OUT);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign p_ready_o   = r_p_ready;
    assign res_valid_o = r_res_valid;
    assign res_word_o  = r_buffer[r_rd_ptr];
    assign res_last_o  = r_res_last;
    assign overflow_o  = r_overflow;
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_fios_result_collector.sv
// ============================================================================
// Module   : tb_fios_result_collector
// Brief    : Scoreboard bench for fios_result_collector with WORD_COUNT=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fios_result_collector;

    localparam int WW = 17;
    localparam int PW = 34;
    localparam int WC = 4;

    logic          clock;
    logic          reset;
    logic          p_valid;
    logic [PW-1:0] p;
    logic          p_last;
    logic          p_ready;
    logic          res_valid;
    logic          res_ready;
    logic [WW-1:0] res_word;
    logic          res_last;
    logic          overflow;
    logic          overrun;
    logic          frame_err;

    typedef struct packed {
        logic [WW-1:0] word;
        logic          last;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_popped = 0;
    logic [PW-1:0] stim [WC];

    logic          prev_stall = 1'b0;
    logic [WW-1:0] prev_word  = '0;
    logic          prev_last  = 1'b0;

    fios_result_collector #(
        .WORD_WIDTH (WW),
        .P_WIDTH    (PW),
        .WORD_COUNT (WC)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .p_valid_i   (p_valid),
        .p_i         (p),
        .p_last_i    (p_last),
        .p_ready_o   (p_ready),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_word_o  (res_word),
        .res_last_o  (res_last),
        .overflow_o  (overflow),
        .overrun_o   (overrun),
        .frame_err_o (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference carry resolution over the current stim[] frame.
    task automatic push_expected();
        logic [PW:0]    acc;
        logic [PW-WW:0] carry;
        logic [WW-1:0]  w [WC];
        carry = '0;
        for (int i = 0; i < WC; i++) begin
            acc   = {1'b0, stim[i]} + (PW+1)'(carry);
            w[i]  = acc[WW-1:0];
            carry = acc[PW:WW];
        end
        for (int i = 0; i < WC; i++) begin
            sb.push_back(exp_t'{word: w[i], last: 1'b0, ovf: carry[PW-WW]});
        end
        sb.push_back(exp_t'{word: carry[WW-1:0], last: 1'b1, ovf: carry[PW-WW]});
    endtask

    task automatic drive_frame(input int last_idx);
        push_expected();
        for (int i = 0; i < WC; i++) begin
            p_valid = 1'b1;
            p       = stim[i];
            p_last  = (i == last_idx);
            @(posedge clock);
            #1;
        end
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(p_ready && sb.size() == 0 && !res_valid) && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("drain_done", {62'd0, p_ready, (sb.size() == 0)}, 64'd3);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("valid_seen", res_valid, 1);
    endtask

    task automatic check_reset_state();
        check("rst_p_ready",   p_ready,   1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last",  res_last,  0);
        check("rst_overflow",  overflow,  0);
        check("rst_overrun",   overrun,   0);
        check("rst_frame_err", frame_err, 0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", res_valid, 1);
                check("hold_word",  res_word,  prev_word);
                check("hold_last",  res_last,  prev_last);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_popped++;
                    check("res_word", res_word, e.word);
                    check("res_last", res_last, e.last);
                    check("overflow", overflow, e.ovf);
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_word  = res_word;
            prev_last  = res_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int n0;
        reset     = 1'b1;
        p_valid   = 1'b0;
        p         = '0;
        p_last    = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state();
        reset = 1'b0;

        // Basic frame with latency checks.
        stim = '{34'd5, 34'd6, 34'd7, 34'd8};
        drive_frame(WC - 1);
        check("lat_flush", res_valid, 0);
        @(posedge clock);
        #1;
        check("lat_first", res_valid, 1);
        wait_idle();

        // Back-to-back: carries into every word.
        stim = '{34'h20000, 34'h20000, 34'h20000, 34'h20000};
        drive_frame(WC - 1);
        wait_idle();

        // Full-scale inputs force a final carry of 2^17.
        stim = '{34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF};
        drive_frame(WC - 1);
        wait_idle();
        check("ovf_after_drain", overflow, 0);

        // Back-pressure: stall three cycles on word 2.
        n0 = n_popped;
        res_ready = 1'b0;
        stim = '{34'h1_2345, 34'h0_ABCD, 34'h2_0001_0000, 34'h3_0000_0007};
        drive_frame(WC - 1);
        wait_valid();
        res_ready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        res_ready = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            check("stall_word", res_word, sb[0].word);
        end
        res_ready = 1'b1;
        wait_idle();
        check("stall_count", n_popped - n0, WC + 1);

        // Input during drain is dropped and flagged.
        res_ready = 1'b0;
        stim = '{34'd100, 34'd200, 34'd300, 34'd400};
        drive_frame(WC - 1);
        wait_valid();
        check("overrun_pre", overrun, 0);
        p_valid = 1'b1;
        p       = 34'h3_FFFF_FFFF;
        @(posedge clock); #1;
        p_valid = 1'b0;
        check("overrun_set", overrun, 1);
        res_ready = 1'b1;
        wait_idle();
        check("overrun_sticky", overrun, 1);

        // Misplaced last marker: frame still completes by count.
        check("frame_err_pre", frame_err, 0);
        stim = '{34'd9, 34'd10, 34'd11, 34'd12};
        drive_frame(1);
        wait_idle();
        check("frame_err_set", frame_err, 1);

        // Reset mid-frame discards partial state.
        stim = '{34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 34'd0, 34'd0};
        for (int i = 0; i < 2; i++) begin
            p_valid = 1'b1;
            p       = stim[i];
            @(posedge clock); #1;
        end
        p_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clock); #1;
        reset   = 1'b0;
        check_reset_state();
        stim = '{34'd1, 34'd2, 34'd3, 34'd4};
        drive_frame(WC - 1);
        wait_idle();
        check("post_overrun",   overrun,   0);
        check("post_frame_err", frame_err, 0);
        check("post_overflow",  overflow,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
